// File: rtl/l0_skew_feeder.sv
// rtl/l0_skew_feeder.sv - per-row staging FIFOs feeding the systolic array west edge with diagonal skew
// Optional macro L0_SKEW_EN: when defined, row r sees the read request r cycles late; otherwise all rows pop together.
module l0_skew_feeder #(
  parameter int row   = 8,
  parameter int bw    = 4,
  parameter int depth = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [row*bw-1:0]   in,
  input  logic                wr,
  input  logic                rd,
  input  logic [1:0]          inst_in,
  output logic [row*bw-1:0]   out_w,
  output logic [2*row-1:0]    inst_w,
  output logic                o_full,
  output logic                o_ready,
  output logic                o_empty,
  output logic                o_underflow
);

  localparam int AW = $clog2(depth);

  logic             wr_acc;
  logic [row-1:0]   row_full;
  logic [row-1:0]   row_empty;
  logic [row-1:0]   row_uf;

  assign wr_acc      = wr & ~o_full;
  assign o_full      = |row_full;
  assign o_ready     = ~o_full;
  assign o_empty     = &row_empty;

`ifdef L0_SKEW_EN
  localparam int CH = (row > 1) ? row - 1 : 1;

  // chain[k] holds {rd, inst_in} delayed by k+1 cycles
  logic [2:0] chain [CH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CH; i++) chain[i] <= 3'b000;
    end else begin
      chain[0] <= {rd, inst_in};
      for (int i = 1; i < CH; i++) chain[i] <= chain[i-1];
    end
  end
`endif

  for (genvar r = 0; r < row; r++) begin : g_row
    logic [bw-1:0] mem [depth];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [AW:0]   cnt;
    logic [2:0]    req;
    logic          pop;
    logic [bw-1:0] out_q;
    logic [1:0]    inst_q;

    if (r == 0) begin : g_req0
      assign req = {rd, inst_in};
    end else begin : g_reqn
`ifdef L0_SKEW_EN
      assign req = chain[r-1];
`else
      assign req = {rd, inst_in};
`endif
    end

    // A push into an empty row is not visible to a pop in the same cycle
    assign pop          = req[2] && (cnt != '0);
    assign row_uf[r]    = req[2] && (cnt == '0);
    assign row_full[r]  = (cnt == (AW+1)'(depth));
    assign row_empty[r] = (cnt == '0);

    always_ff @(posedge clk) begin
      if (wr_acc) mem[wp] <= in[r*bw +: bw];
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        wp     <= '0;
        rp     <= '0;
        cnt    <= '0;
        out_q  <= '0;
        inst_q <= 2'b00;
      end else begin
        if (wr_acc) wp <= wp + 1'b1;
        if (pop) begin
          rp    <= rp + 1'b1;
          out_q <= mem[rp];
        end
        inst_q <= pop ? req[1:0] : 2'b00;
        case ({wr_acc, pop})
          2'b10:   cnt <= cnt + 1'b1;
          2'b01:   cnt <= cnt - 1'b1;
          default: cnt <= cnt;
        endcase
      end
    end

    assign out_w[r*bw +: bw] = out_q;
    assign inst_w[2*r +: 2]  = inst_q;
  end

  always_ff @(posedge clk) begin
    if (reset)       o_underflow <= 1'b0;
    else if (|row_uf) o_underflow <= 1'b1;
  end

endmodule

// File: tb/tb_l0_skew_feeder.sv
// tb/tb_l0_skew_feeder.sv - randomized self-checking bench for l0_skew_feeder against a queue-based model
module tb_l0_skew_feeder;
  localparam int ROW = 8;
  localparam int BW = 4;
  localparam int DEPTH = 16;
  localparam int VW = ROW*BW + 2*ROW + 4;
`ifdef L0_SKEW_EN
  localparam int SKEW = 1;
`else
  localparam int SKEW = 0;
`endif

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [ROW*BW-1:0]   in = '0;
  logic                wr = 1'b0;
  logic                rd = 1'b0;
  logic [1:0]          inst_in = 2'b00;
  logic [ROW*BW-1:0]   out_w;
  logic [2*ROW-1:0]    inst_w;
  logic                o_full, o_ready, o_empty, o_underflow;

  int tests = 0;
  int fails = 0;

  l0_skew_feeder #(.row(ROW), .bw(BW), .depth(DEPTH)) dut (
    .clk(clk), .reset(reset), .in(in), .wr(wr), .rd(rd), .inst_in(inst_in),
    .out_w(out_w), .inst_w(inst_w), .o_full(o_full), .o_ready(o_ready),
    .o_empty(o_empty), .o_underflow(o_underflow)
  );

  always #5 clk = ~clk;

  // Reference model: one queue per row, plus request history by age
  logic [BW-1:0]     q [ROW][$];
  logic [2:0]        hist [ROW];
  logic [ROW*BW-1:0] m_out;
  logic [2*ROW-1:0]  m_inst;
  logic              m_uf;

  function automatic logic m_full();
    for (int r = 0; r < ROW; r++) if (q[r].size() == DEPTH) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic m_empty();
    for (int r = 0; r < ROW; r++) if (q[r].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    return {m_out, m_inst, m_full(), !m_full(), m_empty(), m_uf};
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {out_w, inst_w, o_full, o_ready, o_empty, o_underflow};
  endfunction

  task automatic model_edge();
    logic full_now;
    logic [2:0] h;
    if (reset) begin
      for (int r = 0; r < ROW; r++) begin q[r].delete(); hist[r] = 3'b000; end
      m_out = '0; m_inst = '0; m_uf = 1'b0;
    end else begin
      full_now = m_full();
      for (int k = ROW-1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = {rd, inst_in};
      for (int r = 0; r < ROW; r++) begin
        h = hist[r*SKEW];
        m_inst[2*r +: 2] = 2'b00;
        if (h[2]) begin
          if (q[r].size() > 0) begin
            m_out[r*BW +: BW] = q[r].pop_front();
            m_inst[2*r +: 2] = h[1:0];
          end else begin
            m_uf = 1'b1;
          end
        end
      end
      if (wr && !full_now)
        for (int r = 0; r < ROW; r++) q[r].push_back(in[r*BW +: BW]);
    end
  endtask

  task automatic step(input logic w, input logic [ROW*BW-1:0] d, input logic r, input logic [1:0] ins);
    wr = w; in = d; rd = r; inst_in = ins;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b0, '0, 1'b0, 2'b00);
    reset = 1'b0;
  endtask

  function automatic logic [ROW*BW-1:0] rand_vec();
    logic [ROW*BW-1:0] v;
    v = {$urandom, $urandom};
    return v;
  endfunction

  task automatic test_reset();
    do_reset();
    step(1'b0, '0, 1'b0, 2'b00);
    tests++;
    if (dut_vec() !== {{(ROW*BW){1'b0}}, {(2*ROW){1'b0}}, 4'b0110}) begin
      fails++;
      $display("FAIL reset_idle got %h exp %h", dut_vec(), {{(ROW*BW){1'b0}}, {(2*ROW){1'b0}}, 4'b0110});
    end
  endtask

  task automatic test_burst();
    logic [ROW*BW-1:0] v;
    int first [ROW];
    int beats [ROW];
    do_reset();
    for (int k = 0; k < 3; k++) begin
      for (int r = 0; r < ROW; r++) v[r*BW +: BW] = BW'(r + 1 + k);
      step(1'b1, v, 1'b0, 2'b00);
    end
    for (int r = 0; r < ROW; r++) begin first[r] = -1; beats[r] = 0; end
    for (int c = 1; c <= ROW + 4; c++) begin
      step(1'b0, '0, c <= 3, 2'b10);
      tests++;
      if (dut_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL burst_cycle%0d got %h exp %h", c, dut_vec(), exp_vec());
      end
      for (int r = 0; r < ROW; r++)
        if (inst_w[2*r +: 2] == 2'b10) begin
          beats[r]++;
          if (first[r] < 0) first[r] = c;
        end
    end
    for (int r = 0; r < ROW; r++) begin
      tests++;
      if (beats[r] !== 3 || first[r] !== 1 + r*SKEW) begin
        fails++;
        $display("FAIL burst_row%0d beats %0d first %0d exp beats 3 first %0d", r, beats[r], first[r], 1 + r*SKEW);
      end
    end
    tests++;
    if ({o_empty, o_underflow} !== 2'b10) begin
      fails++;
      $display("FAIL burst_flags got empty=%b uf=%b exp empty=1 uf=0", o_empty, o_underflow);
    end
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int k = 0; k < 5; k++) step(1'b1, rand_vec(), 1'b0, 2'b00);
    for (int k = 0; k < 5 + ROW; k++) step(1'b0, '0, k < 5, 2'b01);
    for (int round = 0; round < 2; round++) begin
      for (int k = 0; k < DEPTH; k++) step(1'b1, rand_vec(), 1'b0, 2'b00);
      tests++;
      if ({o_full, o_ready} !== 2'b10) begin
        fails++;
        $display("FAIL full_flag round%0d got full=%b ready=%b exp full=1 ready=0", round, o_full, o_ready);
      end
      step(1'b1, rand_vec(), 1'b0, 2'b00);
      for (int k = 0; k < DEPTH + ROW; k++) begin
        step(1'b0, '0, k < DEPTH, 2'($urandom_range(1, 3)));
        tests++;
        if (dut_vec() !== exp_vec()) begin
          fails++;
          $display("FAIL drain_round%0d_cycle%0d got %h exp %h", round, k, dut_vec(), exp_vec());
        end
      end
      tests++;
      if ({o_empty, o_underflow} !== 2'b10) begin
        fails++;
        $display("FAIL drain_end round%0d got empty=%b uf=%b exp empty=1 uf=0", round, o_empty, o_underflow);
      end
    end
  endtask

  task automatic test_underflow();
    do_reset();
    step(1'b1, rand_vec(), 1'b0, 2'b00);
    for (int k = 0; k < ROW + 3; k++) begin
      step(1'b0, '0, k < 2, 2'b01);
      tests++;
      if (dut_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL underflow_cycle%0d got %h exp %h", k, dut_vec(), exp_vec());
      end
    end
    tests++;
    if (o_underflow !== 1'b1) begin
      fails++;
      $display("FAIL underflow_sticky got %b exp 1", o_underflow);
    end
    do_reset();
    tests++;
    if (o_underflow !== 1'b0) begin
      fails++;
      $display("FAIL underflow_clear got %b exp 0", o_underflow);
    end
  endtask

  task automatic test_reset_inflight();
    do_reset();
    for (int k = 0; k < 6; k++) step(1'b1, rand_vec(), 1'b0, 2'b00);
    for (int k = 0; k < 4; k++) step(1'b0, '0, 1'b1, 2'b11);
    do_reset();
    tests++;
    if ({out_w, inst_w, o_empty} !== {{(ROW*BW){1'b0}}, {(2*ROW){1'b0}}, 1'b1}) begin
      fails++;
      $display("FAIL reset_inflight got out=%h inst=%h empty=%b exp out=0 inst=0 empty=1", out_w, inst_w, o_empty);
    end
    for (int k = 0; k < ROW; k++) begin
      step(1'b0, '0, 1'b0, 2'b00);
      tests++;
      if (inst_w !== '0) begin
        fails++;
        $display("FAIL late_beat_cycle%0d got inst=%h exp 0", k, inst_w);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      step($urandom_range(0, 99) < 55, rand_vec(), $urandom_range(0, 99) < 40, 2'($urandom));
      tests++;
      if (dut_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL random_cycle%0d got %h exp %h", c, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_burst();
    test_full_wrap();
    test_underflow();
    test_reset_inflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/l0_skew_feeder.md
# l0_skew_feeder

Input-side staging buffer for the systolic MAC array. It accepts one row-wide activation/weight vector per write from SRAM and holds it in a per-row FIFO. On read it drives the west edge of the array (`in_w`/`inst_w` of every row's first tile) with the diagonal skew the array needs: row r is issued r cycles after row 0. It sits directly upstream of the mac_tile array and downstream of the activation/weight SRAM.

## Interface
- `row`, 8: number of array rows (FIFO lanes).
- `bw`, 4: data width per row element.
- `depth`, 16: entries per row FIFO; power of two, ≥2.
- `clk` input 1: clock, rising edge.
- `reset` input 1: synchronous, active-high; clears all state.
- `in` input row*bw: write vector; row r occupies bits [r*bw+bw-1 : r*bw].
- `wr` input 1: push `in` into all row FIFOs this cycle.
- `rd` input 1: issue request; level-sensitive, one pop request per cycle while high.
- `inst_in` input 2: instruction issued with the request ({execute, kernel load}), skewed with data.
- `out_w` output row*bw: per-row data to the array west edge; registered.
- `inst_w` output 2*row: per-row instruction; row r occupies bits [2r+1:2r]; registered.
- `o_full` output 1: some row FIFO holds `depth` entries.
- `o_ready` output 1: equals `!o_full`.
- `o_empty` output 1: all row FIFOs empty.
- `o_underflow` output 1: sticky; a row request hit an empty FIFO.

## Operation
- Storage: per row, a `depth`×`bw` array, write pointer, read pointer (log2(depth) bits, natural wrap-around), and a count (log2(depth)+1 bits).
- Write: accepted only if `wr` is high and `o_full` is 0 in that cycle. Writes while full are dropped silently and leave no state change. An accepted write pushes all rows in the same cycle.
- Request skew: `{rd, inst_in}` enters a shift chain. Row r sees the request delayed by r cycles: row 0 sees it undelayed, row r sees stage r-1 of the chain.
- Pop: row r pops when its request is high and its count is nonzero. It then registers `out_w[r]` = head entry and `inst_w[r]` = that request's inst.
- Empty row with request: no pop. `inst_w[r]` is registered as 2'b00, `out_w[r]` holds its value, and `o_underflow` is set.
- No request: `inst_w[r]` is registered as 2'b00 and `out_w[r]` holds its value. A tile only latches data when its inst is nonzero.
- No bypass: a write and a pop on an empty row in the same cycle do not pop. The new entry becomes visible the next cycle.
- Simultaneous accepted write and pop on one row: the count is unchanged and both pointers advance.
- `o_full` is the OR over rows of (count == depth). It is driven by the last rows, which pop latest.
- `o_empty` is the AND over rows of (count == 0).
- `o_underflow` clears only on reset.

## Timing
- Reset (synchronous): every pointer, count and skew stage is cleared, and `out_w`, `inst_w` and `o_underflow` go to 0. `o_full` is 0, `o_ready` is 1 and `o_empty` is 1 from the first cycle after reset. A reset mid-operation discards all buffered and in-flight skewed requests.
- Flags are combinational from the counts. They reflect writes and pops from the previous edge.
- Latency:
  - `rd` sampled high at edge t: row 0 data/inst are valid after edge t, row r after edge t+r.
  - A write at edge t can be popped by a row-0 request at edge t+1 at the earliest.
- A burst of N consecutive `rd` cycles produces N consecutive valid beats per row, each row r shifted by r cycles.
- The skew chain keeps draining for row-1 cycles after `rd` falls.

## Configuration
- `L0_SKEW_EN` defined: behaviour as above.
- `L0_SKEW_EN` undefined: the skew chain is removed and every row uses the undelayed request, so all rows pop in the same cycle. In this mode the array-level skew must be provided by tile forwarding only. Flags and underflow behave the same.

## Test plan
- Reset then idle: `out_w`=0, `inst_w`=0, `o_empty`=1, `o_full`=0, `o_ready`=1, `o_underflow`=0.
- Write 3 vectors (row r element = r+1, r+2, r+3), then `rd`=1 for 3 cycles with `inst_in`=2'b10.
  - Row r shows r+1, r+2, r+3 in cycles t+1+r..t+3+r, `inst_w[r]`=2'b10 on exactly those cycles and 00 elsewhere.
  - `o_empty`=1 after the row-7 pop; `o_underflow`=0.
- Write 16 vectors with `depth`=16: `o_full`=1. A 17th write is dropped. Reading 16 returns the original 16 in order, with pointer wrap verified by a second 16-entry fill/drain.
- Hold `rd`=1 for 2 cycles with 1 entry stored: row r pops once. The second request gives `inst_w[r]`=00 and `o_underflow`=1, which stays 1 until reset.
- Assert `reset` while 4 skewed requests are in flight: the next cycle has all `inst_w`=0 and `o_empty`=1, and no late beats appear on any row.
- Rebuild with `L0_SKEW_EN` undefined, write 1 vector, `rd` for 1 cycle: all 8 rows are valid in the same cycle, t+1.
